// File: rtl/nx_fifo_ctrl_1ar1w.sv
// nx_fifo_ctrl_1ar1w: valid/ready FIFO controller that drives an external
// 1-async-read / 1-write RAM.
//
// The controller owns the write pointer, the read pointer and an explicit RAM
// occupancy count. With OUT_REG=0, rd_data_o comes straight from ram_dout_i.
// With OUT_REG=1, a one-entry output register adds one slot of capacity and
// takes the RAM read path out of rd_data_o timing.
//
// Optional protocol checker: define NX_FIFO_CTRL_PROTO_CHK_EN to build the
// sticky err_ovfl_o / err_unfl_o flags. Without the macro, both flags are
// tied to 0 and no checker logic exists.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer must hold valid and data
// stable until that transfer. Ready may change freely, and wr_ready_o never
// depends on wr_valid_i.
module nx_fifo_ctrl_1ar1w #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 256,
    parameter int OUT_REG      = 0,
    parameter int AFULL_THRESH = DEPTH - 2,
    localparam int PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW          = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]    used_slots_o,
    output logic             afull_o,
    output logic [PW-1:0]    ram_ra_o,
    input  logic [WIDTH-1:0] ram_dout_i,
    output logic             ram_web_o,
    output logic [PW-1:0]    ram_wa_o,
    output logic [WIDTH-1:0] ram_din_o,
    output logic [WIDTH-1:0] ram_bwe_o,
    output logic             err_ovfl_o,
    output logic             err_unfl_o
);

    localparam logic [31:0] AFULL_U = AFULL_THRESH;

    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d, used_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] oreg_q, oreg_d;
    logic             afull_q, afull_d;
    logic             wr_ready, rd_valid, wr_fire, pop, ram_nempty;

    // Wrapping increment; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next-state logic: handshakes, RAM pop, count and almost-full.
    always_comb begin
        pop        = 1'b0;
        ov_d       = ov_q;
        oreg_d     = oreg_q;
        wr_ready   = (cnt_q < CW'(DEPTH));
        ram_nempty = (cnt_q != '0);
        wr_fire    = wr_valid_i & wr_ready;
        if (OUT_REG != 0) begin
            // Refill the output register whenever it is empty or being drained.
            if ((!ov_q || rd_ready_i) && ram_nempty) begin
                pop    = 1'b1;
                ov_d   = 1'b1;
                oreg_d = ram_dout_i;
            end else if (rd_ready_i) begin
                ov_d = 1'b0;
            end
            rd_valid = ov_q;
        end else begin
            pop      = ram_nempty & rd_ready_i;
            ov_d     = 1'b0;
            rd_valid = ram_nempty;
        end
        wptr_d = wr_fire ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (wr_fire && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!wr_fire && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        used_d  = cnt_d + CW'(ov_d);
        afull_d = (32'(used_d) >= AFULL_U);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            oreg_q  <= '0;
            afull_q <= (AFULL_THRESH == 0);
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            oreg_q  <= oreg_d;
            afull_q <= afull_d;
        end
    end

    assign wr_ready_o   = wr_ready;
    assign rd_valid_o   = rd_valid;
    assign rd_data_o    = (OUT_REG != 0) ? oreg_q : ram_dout_i;
    assign used_slots_o = cnt_q + CW'(ov_q);
    assign afull_o      = afull_q;
    assign ram_ra_o     = rptr_q;
    assign ram_web_o    = ~wr_fire;
    assign ram_wa_o     = wptr_q;
    assign ram_din_o    = wr_data_i;
    assign ram_bwe_o    = '1;

`ifdef NX_FIFO_CTRL_PROTO_CHK_EN
    logic             wr_pend_q, unfl_run_q, err_ovfl_q, err_unfl_q;
    logic [WIDTH-1:0] wr_hold_q;
    logic             unfl_cond;

    // A consumer asking for data while nothing can be popped.
    assign unfl_cond = rd_ready_i & ~rd_valid & ~ram_nempty;

    // Sticky protocol error flags: a stalled write must stay stable,
    // and an underflow is flagged after two consecutive empty read attempts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend_q  <= 1'b0;
            wr_hold_q  <= '0;
            unfl_run_q <= 1'b0;
            err_ovfl_q <= 1'b0;
            err_unfl_q <= 1'b0;
        end else begin
            wr_pend_q  <= wr_valid_i & ~wr_ready;
            wr_hold_q  <= wr_data_i;
            unfl_run_q <= unfl_cond;
            if (wr_pend_q && (!wr_valid_i || (wr_data_i != wr_hold_q))) begin
                err_ovfl_q <= 1'b1;
            end
            if (unfl_cond && unfl_run_q) begin
                err_unfl_q <= 1'b1;
            end
        end
    end

    assign err_ovfl_o = err_ovfl_q;
    assign err_unfl_o = err_unfl_q;
`else
    assign err_ovfl_o = 1'b0;
    assign err_unfl_o = 1'b0;
`endif

endmodule
